// File: rtl/sha_256_stream.sv
// Streaming SHA-256/SHA-224 core: absorbs pre-padded 512-bit blocks, chains H across
// the blocks of a message and presents the digest once the block tagged last completes.
module sha_256_stream #(
    parameter int MSG_SIZ     = 512,
    parameter int HASH_SIZE   = 256,
    parameter int RND_PER_CYC = 1,
    parameter int BLK_CNT_W   = 16
) (
    input  logic                 usr_clk,
    input  logic                 usr_reset_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [MSG_SIZ-1:0]   i_msg,
    input  logic                 i_last,
    input  logic                 i_mode,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [HASH_SIZE-1:0] o_hash,
    output logic [BLK_CNT_W-1:0] o_blk_cnt,
    output logic                 o_busy
);

    generate
        if (MSG_SIZ != 512 || HASH_SIZE != 256 ||
            !(RND_PER_CYC == 1 || RND_PER_CYC == 2 || RND_PER_CYC == 4 || RND_PER_CYC == 8)) begin : g_bad_param
            $error("sha_256_stream: illegal parameter set");
        end
    endgenerate

    localparam logic [5:0] T_STEP = 6'(RND_PER_CYC);
    localparam logic [5:0] T_LAST = 6'(64 - RND_PER_CYC);

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV_256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [31:0] IV_224 [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    typedef enum logic [2:0] {IDLE, WAIT_BLK, COMP, UPDATE, DONE} state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t                 state_q, state_d;
    logic [31:0]            h_q  [8];
    logic [31:0]            h_d  [8];
    logic [31:0]            wk_q [8];
    logic [31:0]            wk_d [8];
    logic [31:0]            w_q  [16];
    logic [31:0]            w_d  [16];
    logic [5:0]             t_q, t_d;
    logic                   mode_q, mode_d;
    logic                   last_q, last_d;
    logic [BLK_CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic [HASH_SIZE-1:0]   hash_q, hash_d;

    logic [31:0]            msg_w [16];
    logic [31:0]            wk_c  [8];
    logic [31:0]            win_c [16];
    logic [5:0]             k_idx;
    logic [31:0]            t1, t2, w_new;
    logic                   ready_c;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_msg_word
            assign msg_w[gi] = i_msg[MSG_SIZ-1-32*gi -: 32];
        end
    endgenerate

    // RND_PER_CYC rounds chained combinationally; the window slides by one word per round.
    always_comb begin
        wk_c  = wk_q;
        win_c = w_q;
        k_idx = t_q;
        t1    = '0;
        t2    = '0;
        w_new = '0;
        for (int r = 0; r < RND_PER_CYC; r++) begin
            k_idx = t_q + 6'(r);
            t1 = wk_c[7] + big_sig1(wk_c[4]) + ((wk_c[4] & wk_c[5]) ^ (~wk_c[4] & wk_c[6]))
               + K_ROM[k_idx] + win_c[0];
            t2 = big_sig0(wk_c[0]) + ((wk_c[0] & wk_c[1]) ^ (wk_c[0] & wk_c[2]) ^ (wk_c[1] & wk_c[2]));
            w_new = small_sig1(win_c[14]) + win_c[9] + small_sig0(win_c[1]) + win_c[0];
            for (int j = 7; j > 0; j--) begin
                wk_c[j] = wk_c[j-1];
            end
            wk_c[4] = wk_c[4] + t1;
            wk_c[0] = t1 + t2;
            for (int j = 0; j < 15; j++) begin
                win_c[j] = win_c[j+1];
            end
            win_c[15] = w_new;
        end
    end

    assign ready_c = (state_q == IDLE) || (state_q == WAIT_BLK);

    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        wk_d      = wk_q;
        w_d       = w_q;
        t_d       = t_q;
        mode_d    = mode_q;
        last_d    = last_q;
        blk_cnt_d = blk_cnt_q;
        hash_d    = hash_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    w_d       = msg_w;
                    mode_d    = i_mode;
                    last_d    = i_last;
                    h_d       = i_mode ? IV_224 : IV_256;
                    wk_d      = i_mode ? IV_224 : IV_256;
                    blk_cnt_d = BLK_CNT_W'(1);
                    t_d       = '0;
                    state_d   = COMP;
                end
            end
            WAIT_BLK: begin
                if (i_valid) begin
                    w_d     = msg_w;
                    last_d  = i_last;
                    wk_d    = h_q;
                    t_d     = '0;
                    state_d = COMP;
                    if (blk_cnt_q != '1) begin
                        blk_cnt_d = blk_cnt_q + BLK_CNT_W'(1);
                    end
                end
            end
            COMP: begin
                wk_d = wk_c;
                w_d  = win_c;
                t_d  = t_q + T_STEP;
                if (t_q == T_LAST) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                for (int i = 0; i < 8; i++) begin
                    h_d[i] = h_q[i] + wk_q[i];
                end
                if (last_q) begin
                    for (int i = 0; i < 8; i++) begin
                        hash_d[255-32*i -: 32] = h_d[i];
                    end
                    // SHA-224 truncates to H0..H6; the low word is forced to zero.
                    if (mode_q) begin
                        hash_d[31:0] = '0;
                    end
                    state_d = DONE;
                end else begin
                    state_d = WAIT_BLK;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge usr_clk) begin
        if (!usr_reset_n) begin
            state_q   <= IDLE;
            hash_q    <= '0;
            blk_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hash_q    <= hash_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    // Datapath state is only meaningful after an accept, so it carries no reset.
    always_ff @(posedge usr_clk) begin
        h_q    <= h_d;
        wk_q   <= wk_d;
        w_q    <= w_d;
        t_q    <= t_d;
        mode_q <= mode_d;
        last_q <= last_d;
    end

    assign o_ready   = ready_c;
    assign o_valid   = (state_q == DONE);
    assign o_busy    = (state_q != IDLE);
    assign o_hash    = hash_q;
    assign o_blk_cnt = blk_cnt_q;

endmodule

// File: tb/tb_sha_256_stream.sv
// Bench for sha_256_stream: four instances (1/2/4/8 rounds per clock) driven in turn
// with directed messages; expected digests are queued on accept and checked on output.
module tb_sha_256_stream;

    localparam logic [255:0] H256_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] H256_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] H224_ABC = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7_00000000;
    localparam logic [255:0] H224_TWO = 256'h75388b16512776cc5dba5da1fd890150b0c6455cb4f58b1952522525_00000000;

    localparam logic [511:0] MSG_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] MSG_TWO_A = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] MSG_TWO_B = {480'h0, 32'h000001c0};

    typedef struct packed {
        logic [255:0] hash;
        logic [15:0]  cnt;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_valid;
    logic [511:0] i_msg;
    logic         i_last;
    logic         i_mode;
    logic         i_ready;
    logic [1:0]   sel;

    logic         o_ready_a [4];
    logic         o_valid_a [4];
    logic         o_busy_a  [4];
    logic [255:0] o_hash_a  [4];
    logic [15:0]  o_cnt_a   [4];

    logic         d_ready, d_valid, d_busy;
    logic [255:0] d_hash;
    logic [15:0]  d_cnt;

    int   cyc = 0;
    int   acc_cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            sha_256_stream #(
                .MSG_SIZ    (512),
                .HASH_SIZE  (256),
                .RND_PER_CYC(1 << gi),
                .BLK_CNT_W  (16)
            ) u_dut (
                .usr_clk    (clk),
                .usr_reset_n(rst_n),
                .i_valid    (i_valid && (sel == 2'(gi))),
                .o_ready    (o_ready_a[gi]),
                .i_msg      (i_msg),
                .i_last     (i_last),
                .i_mode     (i_mode),
                .o_valid    (o_valid_a[gi]),
                .i_ready    (i_ready && (sel == 2'(gi))),
                .o_hash     (o_hash_a[gi]),
                .o_blk_cnt  (o_cnt_a[gi]),
                .o_busy     (o_busy_a[gi])
            );
        end
    endgenerate

    assign d_ready = o_ready_a[sel];
    assign d_valid = o_valid_a[sel];
    assign d_busy  = o_busy_a[sel];
    assign d_hash  = o_hash_a[sel];
    assign d_cnt   = o_cnt_a[sel];

    function automatic int rnd();
        return 1 << sel;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s R=%0d: observed %h, expected %h", tag, rnd(), obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s R=%0d: observed %0d, expected %0d", tag, rnd(), obs, exp);
        end
    endtask

    // Present one block and hold it until accepted; queue the expected digest if requested.
    task automatic send(input logic [511:0] msg, input logic last, input logic mode,
                        input bit push, input logic [15:0] cnt, input logic [255:0] hash);
        int n;
        i_valid = 1'b1;
        i_msg   = msg;
        i_last  = last;
        i_mode  = mode;
        n = 0;
        while (!d_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 256'(d_ready), 256'(1));
        acc_cyc = cyc;
        if (push) sb.push_back('{hash: hash, cnt: cnt});
        @(negedge clk);
        i_valid = 1'b0;
        i_mode  = ~mode;
    endtask

    // Wait for the digest, compare against the scoreboard, optionally stall, then handshake.
    task automatic get_digest(input int hold);
        int   n;
        exp_t e;
        n = 0;
        while (!d_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("valid_seen", 256'(d_valid), 256'(1));
        if (!d_valid) return;
        check_int("latency", cyc - acc_cyc, 64 / rnd() + 2);
        check_int("sb_nonempty", sb.size(), (sb.size() == 0) ? 1 : sb.size());
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("hash", d_hash, e.hash);
        check("blk_cnt", 256'(d_cnt), 256'(e.cnt));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_valid", 256'(d_valid), 256'(1));
            check("bp_hash", d_hash, e.hash);
            check("bp_ready", 256'(d_ready), 256'(0));
        end
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        check("post_valid", 256'(d_valid), 256'(0));
        check("post_ready", 256'(d_ready), 256'(1));
        check("post_busy", 256'(d_busy), 256'(0));
        check("post_hash", d_hash, e.hash);
        check("post_cnt", 256'(d_cnt), 256'(e.cnt));
    endtask

    initial begin
        int seen;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_msg   = '0;
        i_last  = 1'b0;
        i_mode  = 1'b0;
        i_ready = 1'b0;
        sel     = 2'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sel = 2'(k);
            #1;
            check("rst_ready", 256'(d_ready), 256'(1));
            check("rst_valid", 256'(d_valid), 256'(0));
            check("rst_busy", 256'(d_busy), 256'(0));
            check("rst_hash", d_hash, 256'(0));
            check("rst_cnt", 256'(d_cnt), 256'(0));
        end
        @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            sel = 2'(k);
            $display("R=%0d: SHA-256 abc", rnd());
            send(MSG_ABC, 1'b1, 1'b0, 1'b1, 16'd1, H256_ABC);
            get_digest(0);

            $display("R=%0d: SHA-256 two-block", rnd());
            send(MSG_TWO_A, 1'b0, 1'b0, 1'b0, 16'd0, '0);
            seen = acc_cyc;
            send(MSG_TWO_B, 1'b1, 1'b1, 1'b1, 16'd2, H256_TWO);
            check_int("ready_return", acc_cyc - seen, 64 / rnd() + 2);
            get_digest(0);

            $display("R=%0d: SHA-224 abc", rnd());
            send(MSG_ABC, 1'b1, 1'b1, 1'b1, 16'd1, H224_ABC);
            get_digest(0);

            $display("R=%0d: SHA-224 two-block, mode toggled on block 2", rnd());
            send(MSG_TWO_A, 1'b0, 1'b1, 1'b0, 16'd0, '0);
            send(MSG_TWO_B, 1'b1, 1'b0, 1'b1, 16'd2, H224_TWO);
            get_digest(0);

            $display("R=%0d: backpressure then back-to-back abc", rnd());
            send(MSG_ABC, 1'b1, 1'b0, 1'b1, 16'd1, H256_ABC);
            get_digest(20);
            send(MSG_ABC, 1'b1, 1'b0, 1'b1, 16'd1, H256_ABC);
            get_digest(0);

            $display("R=%0d: reset during COMP", rnd());
            send(MSG_TWO_A, 1'b1, 1'b1, 1'b0, 16'd0, '0);
            repeat (9) @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check("abort_busy", 256'(d_busy), 256'(0));
            check("abort_ready", 256'(d_ready), 256'(1));
            check("abort_valid", 256'(d_valid), 256'(0));
            check("abort_hash", d_hash, 256'(0));
            seen = 0;
            repeat (80) begin
                @(negedge clk);
                if (d_valid) seen++;
            end
            check_int("abort_no_digest", seen, 0);
            send(MSG_ABC, 1'b1, 1'b0, 1'b1, 16'd1, H256_ABC);
            get_digest(0);
        end

        check_int("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
